// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/FIFO sizes and the capture FSM encoding.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned DATA_W_DEF = FRAME_BITS;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_WAIT_CLR = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head (o_data/o_valid change only on the clock edge).
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              push_s, pop_s, full_s;

    assign full_s = (level_q == LVL_FULL);
    assign pop_s  = i_pop & valid_q;
    assign push_s = i_push & (~full_s | pop_s);

    // Next pointers, occupancy and head; a push landing on the next read slot bypasses the array.
    always_comb begin
        wptr_d = push_s ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d = pop_s ? (rptr_q + PTR_ONE) : rptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        valid_d = (level_d != {LW{1'b0}});
        if (level_d == {LW{1'b0}}) begin
            data_d = {DATA_W{1'b0}};
        end else if (push_s && (wptr_q == rptr_d)) begin
            data_d = i_wdata;
        end else begin
            data_d = mem_q[rptr_d];
        end
    end

    // Storage array write port.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= i_wdata;
        end
    end

    // Pointer, level and registered head state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            level_q <= {LW{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_level = level_q;
    assign o_full  = full_s;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receiver-side frame capture, flush handshake, overflow/drop bookkeeping and FIFO buffering.
// Optional build macro UART_RX_FIFO_DROP_INVALID_EN discards frames whose parity flag is low.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [DATA_W-1:0]      i_rx_data,
    input  logic                   i_converted,
    input  logic                   i_data_valid,
    output logic                   o_flush,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    input  logic                   i_clr_ovf,
    output logic [CNT_W-1:0]       o_drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    cap_state_e       state_q;
    logic             flush_q;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             fifo_valid_s, fifo_full_s;
    logic             capture_s, frame_ok_s, pop_s, push_s, ovf_set_s, drop_s;

`ifdef UART_RX_FIFO_DROP_INVALID_EN
    assign frame_ok_s = i_data_valid;
`else
    logic unused_data_valid_s;
    assign unused_data_valid_s = i_data_valid;
    assign frame_ok_s = 1'b1;
`endif

    // A frame is only sampled on the first cycle the FSM sees converted while idle.
    assign capture_s = (state_q == S_IDLE) & i_converted;
    assign pop_s     = fifo_valid_s & i_ready;
    assign push_s    = capture_s & frame_ok_s & (~fifo_full_s | pop_s);
    assign ovf_set_s = capture_s & frame_ok_s & fifo_full_s & ~pop_s;
    assign drop_s    = capture_s & (~frame_ok_s | (fifo_full_s & ~pop_s));

    // Sticky overflow (set beats clear) and saturating drop counter.
    always_comb begin
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (drop_s && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + CNT_ONE;
        end else begin
            drop_d = drop_q;
        end
    end

    // Capture FSM with registered one-cycle flush pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            flush_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_converted) begin
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    state_q <= S_WAIT_CLR;
                    flush_q <= 1'b0;
                end
                S_WAIT_CLR: begin
                    state_q <= i_converted ? S_WAIT_CLR : S_IDLE;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    // Overflow flag and drop counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q  <= 1'b0;
            drop_q <= {CNT_W{1'b0}};
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_wdata (i_rx_data),
        .i_pop   (pop_s),
        .o_data  (o_data),
        .o_valid (fifo_valid_s),
        .o_level (o_level),
        .o_full  (fifo_full_s)
    );

    assign o_valid    = fifo_valid_s;
    assign o_flush    = flush_q;
    assign o_overflow = ovf_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based frame model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       converted, data_valid, ready, clr_ovf;
    logic       flush, valid, overflow;
    logic [7:0] dout, drop_cnt;
    logic [4:0] level;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_converted  (converted),
        .i_data_valid (data_valid),
        .o_flush      (flush),
        .o_data       (dout),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_level      (level),
        .o_overflow   (overflow),
        .i_clr_ovf    (clr_ovf),
        .o_drop_cnt   (drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame queue plus sticky flag, drop count and receiver arming.
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    logic       m_ovf;
    logic [7:0] m_drop;
    bit         armed;
    int         since;
    int         flush_exp, flush_obs;
    int         max_level;

    task automatic model_reset();
        mq.delete();
        popped.delete();
        m_ovf = 1'b0; m_drop = 8'd0; armed = 1'b1; since = 0;
        flush_exp = 0; flush_obs = 0; max_level = 0;
    endtask

    // Observe the current cycle, advance the model across the edge, then move to the next cycle.
    task automatic step();
        bit pop, cap, full, ok, ovf_set;
        ok = 1'b1; ovf_set = 1'b0;
        if (flush) flush_obs++;
        if (valid && ready) popped.push_back(dout);
        if (int'(level) > max_level) max_level = int'(level);
        pop  = (mq.size() != 0) && ready;
        cap  = armed && converted;
        full = (mq.size() == DEPTH);
        if (cap) begin
            flush_exp++;
            armed = 1'b0; since = 0;
`ifdef UART_RX_FIFO_DROP_INVALID_EN
            ok = data_valid;
`endif
            if (!ok || (full && !pop)) begin
                if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                if (ok) ovf_set = 1'b1;
            end
        end else if (!armed) begin
            since++;
            if (since >= 2 && !converted) armed = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (cap && ok && !(full && !pop)) mq.push_back(rx_data);
        if (ovf_set) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic v, input int hold,
                              input logic rdy_cap, input logic rdy_rest, input logic clr_cap);
        converted = 1'b1; rx_data = d; data_valid = v; ready = rdy_cap; clr_ovf = clr_cap;
        step();
        ready = rdy_rest; clr_ovf = 1'b0;
        step();
        for (int i = 0; i < hold; i++) step();
        converted = 1'b0; data_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; converted = 1'b0; data_valid = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; converted = 1'b0; data_valid = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h want 0", dout); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        converted = 1'b1; rx_data = 8'h5A; data_valid = 1'b1; ready = 1'b0;
        n_cmp++; if (flush !== 1'b0 || valid !== 1'b0) begin
            n_bad++; $display("FAIL single_capture_cycle: flush=%b valid=%b want 0 0", flush, valid);
        end
        step();
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL single_flush: got %b want 1", flush); end
        n_cmp++; if (valid !== 1'b1 || dout !== 8'h5A) begin
            n_bad++; $display("FAIL single_head: valid=%b data=%0h want 1 5a", valid, dout);
        end
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL single_level: got %0d want 1", level); end
        step();
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL single_flush_width: got %b want 0", flush); end
        converted = 1'b0;
        step();
    endtask

    task automatic test_held();
        int lvl0;
        lvl0 = int'(level);
        send_frame(8'hC3, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (int'(level) !== lvl0 + 1) begin
            n_bad++; $display("FAIL held_one_push: got %0d want %0d", level, lvl0 + 1);
        end
        n_cmp++; if (flush_obs !== flush_exp || flush_obs !== 2) begin
            n_bad++; $display("FAIL held_one_flush: got %0d want 2", flush_obs);
        end
        send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (int'(level) !== lvl0 + 2) begin
            n_bad++; $display("FAIL held_rearm: got %0d want %0d", level, lvl0 + 2);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fill_level: got %0d want 16", level); end
        send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fill_drop_level: got %0d want 16", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_ovf: got %b want 1", overflow); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL fill_drop: got %0d want 1", drop_cnt); end
        n_cmp++; if (flush_obs !== 17) begin n_bad++; $display("FAIL fill_flush: got %0d want 17", flush_obs); end
        n_cmp++; if (dout !== mq[0]) begin n_bad++; $display("FAIL fill_head: got %0h want %0h", dout, mq[0]); end
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0; step();
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd1) begin
            n_bad++; $display("FAIL clr_ovf: ovf=%b drop=%0d want 0 1", overflow, drop_cnt);
        end
        send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            n_bad++; $display("FAIL set_wins: ovf=%b drop=%0d want 1 2", overflow, drop_cnt);
        end
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_head;
        exp_head = mq[1];
        send_frame(8'hA7, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fpp_level: got %0d want 16", level); end
        n_cmp++; if (dout !== exp_head) begin n_bad++; $display("FAIL fpp_head: got %0h want %0h", dout, exp_head); end
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd2) begin
            n_bad++; $display("FAIL fpp_noovf: ovf=%b drop=%0d want 0 2", overflow, drop_cnt);
        end
        n_cmp++; if (mq[DEPTH-1] !== 8'hA7) begin
            n_bad++; $display("FAIL fpp_tail: model tail %0h want a7", mq[DEPTH-1]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 40; i++) send_frame(8'(i), 1'b1, 0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (popped.size() !== 40) begin
            n_bad++; $display("FAIL wrap_count: got %0d want 40", popped.size());
        end
        for (int i = 0; i < 40 && i < popped.size(); i++) begin
            n_cmp++; if (popped[i] !== 8'(i)) begin
                n_bad++; $display("FAIL wrap_order[%0d]: got %0h want %0h", i, popped[i], 8'(i));
            end
        end
        n_cmp++; if (max_level > 1) begin n_bad++; $display("FAIL wrap_maxlevel: got %0d want <=1", max_level); end
        ready = 1'b0;
    endtask

    task automatic test_invalid();
        int lvl0;
        logic [7:0] drop0;
        do_reset();
        send_frame(8'h42, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        lvl0 = int'(level); drop0 = drop_cnt;
        send_frame(8'h99, 1'b0, 1, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_DROP_INVALID_EN
        n_cmp++; if (int'(level) !== lvl0 || drop_cnt !== drop0 + 8'd1) begin
            n_bad++; $display("FAIL invalid_drop: level=%0d drop=%0d want %0d %0d", level, drop_cnt, lvl0, drop0 + 8'd1);
        end
`else
        n_cmp++; if (int'(level) !== lvl0 + 1 || drop_cnt !== drop0) begin
            n_bad++; $display("FAIL invalid_kept: level=%0d drop=%0d want %0d %0d", level, drop_cnt, lvl0 + 1, drop0);
        end
`endif
        n_cmp++; if (overflow !== 1'b0 || flush_obs !== 2) begin
            n_bad++; $display("FAIL invalid_flush: ovf=%b flushes=%0d want 0 2", overflow, flush_obs);
        end
        n_cmp++; if (int'(level) !== mq.size() || drop_cnt !== m_drop) begin
            n_bad++; $display("FAIL invalid_model: level=%0d drop=%0d want %0d %0d", level, drop_cnt, mq.size(), m_drop);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 80; f++) begin
            converted = 1'b1; rx_data = 8'($urandom); data_valid = ($urandom_range(0, 4) != 0);
            ready = ($urandom_range(0, 4) == 0); clr_ovf = ($urandom_range(0, 9) == 0);
            step();
            for (int c = 0; c < 1 + int'($urandom_range(0, 3)); c++) begin
                ready = ($urandom_range(0, 4) == 0); clr_ovf = ($urandom_range(0, 9) == 0);
                step();
            end
            converted = 1'b0; ready = ($urandom_range(0, 4) == 0); clr_ovf = 1'b0;
            step();
            n_cmp++; if (int'(level) !== mq.size() || valid !== (mq.size() != 0)) begin
                n_bad++; $display("FAIL rand_level f%0d: level=%0d valid=%b want %0d", f, level, valid, mq.size());
            end
            if (mq.size() != 0) begin
                n_cmp++; if (dout !== mq[0]) begin
                    n_bad++; $display("FAIL rand_head f%0d: got %0h want %0h", f, dout, mq[0]);
                end
            end
            n_cmp++; if (overflow !== m_ovf || drop_cnt !== m_drop || flush_obs !== flush_exp) begin
                n_bad++; $display("FAIL rand_status f%0d: ovf=%b drop=%0d fl=%0d want %b %0d %0d",
                                  f, overflow, drop_cnt, flush_obs, m_ovf, m_drop, flush_exp);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < DEPTH + 260; i++) send_frame(8'($urandom), 1'b1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (drop_cnt !== 8'hFF || m_drop !== 8'hFF) begin
            n_bad++; $display("FAIL sat_drop: got %0d want 255", drop_cnt);
        end
        n_cmp++; if (level !== 5'd16 || overflow !== 1'b1) begin
            n_bad++; $display("FAIL sat_state: level=%0d ovf=%b want 16 1", level, overflow);
        end
    endtask

    task automatic test_reset_midrun();
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        converted = 1'b1; rx_data = 8'hB4; data_valid = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (flush !== 1'b0 || valid !== 1'b0 || level !== 5'd0) begin
            n_bad++; $display("FAIL midrst_fifo: flush=%b valid=%b level=%0d want 0 0 0", flush, valid, level);
        end
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0 || dout !== 8'h00) begin
            n_bad++; $display("FAIL midrst_status: ovf=%b drop=%0d data=%0h want 0 0 0", overflow, drop_cnt, dout);
        end
        rst_n = 1'b1;
        model_reset();
        step();
        step();
        converted = 1'b0;
        step();
        n_cmp++; if (flush_obs !== 1 || level !== 5'd1 || dout !== 8'hB4) begin
            n_bad++; $display("FAIL midrst_recapture: flushes=%0d level=%0d data=%0h want 1 1 b4", flush_obs, level, dout);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_invalid();
        test_random();
        test_saturate();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
